periph_intc: RTL

On-chip peripheral interrupt arbiter for the SH core. It takes level interrupt requests from the FRT (ICI, OCIA, OCIB, OVI), the SCI (ERI, RXI, TXI, TEI) and the WDT (ITI). It applies the programmable priorities in IPRA/IPRB and the vectors in VCRA–VCRD/VCRWDT. It presents the single highest-priority request to the CPU exception logic as a registered level/vector pair, with a hold handshake during vector acceptance.

---
 rtl/periph_intc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/periph_intc.sv
// Peripheral interrupt arbiter: FRT/SCI/WDT level requests -> registered {level, vector}.
// Optional WDT source and its IPRA/VCRWDT registers are enabled by `PERIPH_INTC_WDT_EN.
module periph_intc (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic        ICI_IRQ,
    input  logic        OCIA_IRQ,
    input  logic        OCIB_IRQ,
    input  logic        OVI_IRQ,
    input  logic        ERI_IRQ,
    input  logic        RXI_IRQ,
    input  logic        TXI_IRQ,
    input  logic        TEI_IRQ,
    input  logic        ITI_IRQ,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic [3:0]  INT_LVL,
    output logic [6:0]  INT_VEC,
    input  logic        INT_ACK
);

    localparam logic [15:0] IPRA_MASK = 16'h00F0;
    localparam logic [15:0] IPRB_MASK = 16'hFF00;
    localparam logic [15:0] VCR_MASK  = 16'h7F7F;
    localparam logic [15:0] VCRD_MASK = 16'h7F00;

    function automatic logic [15:0] wr_merge(input logic [15:0] old, input logic [15:0] wd,
                                             input logic [1:0] be, input logic [15:0] keep);
        logic [15:0] bm;
        bm = {{8{be[1]}}, {8{be[0]}}};
        return ((old & ~bm) | (wd & bm)) & keep;
    endfunction

    logic [15:0] ipra_q, vcrwdt_q, iprb_q, vcra_q, vcrb_q, vcrc_q, vcrd_q;
    logic        hi_page_s, frt_sci_hit_s, wdt_hit_s, sel_s, wr_s, iti_s;
    logic [6:0]  word_s;
    logic [15:0] wd_s, rd_s;
    logic [1:0]  be_s;
    logic [31:0] do_q;

    assign hi_page_s     = (IBUS_A[31:8] == 24'hFFFFFE);
    assign frt_sci_hit_s = hi_page_s && (IBUS_A[7:0] >= 8'h60) && (IBUS_A[7:0] <= 8'h69);
`ifdef PERIPH_INTC_WDT_EN
    assign wdt_hit_s     = hi_page_s && (IBUS_A[7:0] >= 8'hE2) && (IBUS_A[7:0] <= 8'hE5);
    assign iti_s         = ITI_IRQ;
`else
    assign wdt_hit_s     = 1'b0;
    assign iti_s         = 1'b0;
`endif
    assign sel_s  = IBUS_REQ && (frt_sci_hit_s || wdt_hit_s);
    assign wr_s   = sel_s && IBUS_WE && CE_R;
    assign word_s = IBUS_A[7:1];
    assign wd_s   = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
    assign be_s   = IBUS_A[1] ? IBUS_BA[1:0] : IBUS_BA[3:2];

    wire unused_s = &{1'b0, IBUS_A[0], ITI_IRQ};

    // FRT/SCI priority and vector registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            iprb_q <= 16'h0000; vcra_q <= 16'h0000; vcrb_q <= 16'h0000;
            vcrc_q <= 16'h0000; vcrd_q <= 16'h0000;
        end else if (CE_R) begin
            if (!RES_N) begin
                iprb_q <= 16'h0000; vcra_q <= 16'h0000; vcrb_q <= 16'h0000;
                vcrc_q <= 16'h0000; vcrd_q <= 16'h0000;
            end else if (wr_s) begin
                case (word_s)
                    7'h30:   iprb_q <= wr_merge(iprb_q, wd_s, be_s, IPRB_MASK);
                    7'h31:   vcra_q <= wr_merge(vcra_q, wd_s, be_s, VCR_MASK);
                    7'h32:   vcrb_q <= wr_merge(vcrb_q, wd_s, be_s, VCR_MASK);
                    7'h33:   vcrc_q <= wr_merge(vcrc_q, wd_s, be_s, VCR_MASK);
                    7'h34:   vcrd_q <= wr_merge(vcrd_q, wd_s, be_s, VCRD_MASK);
                    default: ;
                endcase
            end
        end
    end

`ifdef PERIPH_INTC_WDT_EN
    // WDT priority and vector registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ipra_q <= 16'h0000; vcrwdt_q <= 16'h0000;
        end else if (CE_R) begin
            if (!RES_N) begin
                ipra_q <= 16'h0000; vcrwdt_q <= 16'h0000;
            end else if (wr_s) begin
                case (word_s)
                    7'h71:   ipra_q   <= wr_merge(ipra_q, wd_s, be_s, IPRA_MASK);
                    7'h72:   vcrwdt_q <= wr_merge(vcrwdt_q, wd_s, be_s, VCR_MASK);
                    default: ;
                endcase
            end
        end
    end
`else
    assign ipra_q   = 16'h0000;
    assign vcrwdt_q = 16'h0000;
`endif

    // Read-back mux for the addressed register
    always_comb begin
        rd_s = 16'h0000;
        case (word_s)
            7'h30:   rd_s = iprb_q;
            7'h31:   rd_s = vcra_q;
            7'h32:   rd_s = vcrb_q;
            7'h33:   rd_s = vcrc_q;
            7'h34:   rd_s = vcrd_q;
            7'h71:   rd_s = ipra_q;
            7'h72:   rd_s = vcrwdt_q;
            default: rd_s = 16'h0000;
        endcase
    end

    // Read data register, updated on the falling-phase enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do_q <= 32'h0000_0000;
        end else if (CE_F) begin
            if (!sel_s)         do_q <= 32'h0000_0000;
            else if (IBUS_A[1]) do_q <= {16'h0000, rd_s};
            else                do_q <= {rd_s, 16'h0000};
        end
    end

    assign IBUS_DO   = do_q;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_ACT  = sel_s;

    // Source index order doubles as tie order: 0 = ITI (highest) ... 7 = OVI (lowest)
    logic [7:0]      req_s, s1_req_q;
    logic [7:0][3:0] lvl_s, s1_lvl_q;
    logic [7:0][6:0] vec_s, s1_vec_q;
    logic [3:0]      lvl_d, lvl_q;
    logic [6:0]      vec_d, vec_q;

    assign req_s = {OVI_IRQ, OCIA_IRQ | OCIB_IRQ, ICI_IRQ, TEI_IRQ, TXI_IRQ, RXI_IRQ, ERI_IRQ, iti_s};
    assign lvl_s = {{3{iprb_q[11:8]}}, {4{iprb_q[15:12]}}, ipra_q[7:4]};
    assign vec_s = {vcrd_q[14:8], vcrc_q[6:0], vcrc_q[14:8], vcrb_q[6:0],
                    vcrb_q[14:8], vcra_q[6:0], vcra_q[14:8], vcrwdt_q[14:8]};

    // Stage 1: sample requests with their level and vector
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_req_q <= 8'h00; s1_lvl_q <= '0; s1_vec_q <= '0;
        end else if (CE_R) begin
            if (!RES_N) begin
                s1_req_q <= 8'h00; s1_lvl_q <= '0; s1_vec_q <= '0;
            end else begin
                s1_req_q <= req_s; s1_lvl_q <= lvl_s; s1_vec_q <= vec_s;
            end
        end
    end

    // Stage 2 select: scanning low-to-high priority with >= lets the earlier source win ties
    always_comb begin
        lvl_d = 4'h0;
        vec_d = 7'h00;
        for (int i = 7; i >= 0; i--) begin
            vec_d = (s1_req_q[i] && (s1_lvl_q[i] != 4'h0) && (s1_lvl_q[i] >= lvl_d)) ? s1_vec_q[i] : vec_d;
            lvl_d = (s1_req_q[i] && (s1_lvl_q[i] != 4'h0) && (s1_lvl_q[i] >= lvl_d)) ? s1_lvl_q[i] : lvl_d;
        end
    end

    // Stage 2: output pair, frozen while the CPU accepts the vector
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lvl_q <= 4'h0; vec_q <= 7'h00;
        end else if (CE_R) begin
            if (!RES_N) begin
                lvl_q <= 4'h0; vec_q <= 7'h00;
            end else if (!INT_ACK) begin
                lvl_q <= lvl_d; vec_q <= vec_d;
            end
        end
    end

    assign INT_LVL = lvl_q;
    assign INT_VEC = vec_q;

endmodule
